rs232_tx_sched: RTL

- Round-robin scheduler that shares one RS232 transmitter core (STT in, EOT out, 12-state bit sequencer) among 4 byte-producing requesters.
- Generates the baud enable tick for the transmitter.
- Latches the granted byte, issues STT, and tracks EOT through the whole frame.
- Enforces an inter-frame gap and a start-timeout watchdog.
- Sits between application producers and the TX sequencer/shift register.

---
 rtl/rs232_tx_sched.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/rs232_tx_sched.sv
// rs232_tx_sched -- round-robin scheduler sharing one RS232 transmitter
// among four byte producers. It generates the baud enable, grants one
// requester at a time, latches its byte, drives STT and follows EOT
// through the frame. It also enforces an inter-frame gap and a
// start-timeout watchdog.
//
// Optional build macro: RS232_TX_SCHED_CNT_EN adds the FRAMES output,
// a 16-bit count of completed frames. Timeouts are not counted.
//
// Ports:
//   CLK        system clock
//   RST        asynchronous, active-high reset
//   REQ[3:0]   per-requester byte valid, held until granted
//   DIN[31:0]  requester bytes; requester i drives DIN[8i+7:8i]
//   GNT[3:0]   one-hot, one-CLK grant pulse; DIN byte is consumed that cycle
//   BAUD_TICK  one-CLK pulse every BAUD_DIV cycles (transmitter enable)
//   TX_DATA    byte latched for the transmitter shift register
//   STT        start-of-transmission to the transmitter
//   EOT        end-of-transmission from the transmitter (high = idle)
//   BUSY       high whenever the scheduler is not idle
//   OWNER[1:0] requester currently owning the transmitter
//   ERR        sticky start-timeout flag
//   FRAMES     completed-frame counter (only with RS232_TX_SCHED_CNT_EN)
module rs232_tx_sched #(
  parameter int unsigned BAUD_DIV      = 5208,
  parameter int unsigned GAP_TICKS     = 1,
  parameter int unsigned TIMEOUT_TICKS = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  REQ,
  input  logic [31:0] DIN,
  output logic [3:0]  GNT,
  output logic        BAUD_TICK,
  output logic [7:0]  TX_DATA,
  output logic        STT,
  input  logic        EOT,
  output logic        BUSY,
  output logic [1:0]  OWNER,
  output logic        ERR
`ifdef RS232_TX_SCHED_CNT_EN
  ,
  output logic [15:0] FRAMES
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SEND  = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] baud_cnt;
  logic [15:0] tick_cnt, tick_cnt_nxt;
  logic [1:0]  last;
  logic [1:0]  win;
  logic        any_req;
  logic        grant;
  logic        err_set;
  logic        frame_done;
  logic        timeout_hit;
  logic        gap_done;

  // Free-running baud divider; the tick is a decode of the counter so it
  // is low during reset and exactly one CLK wide.
  assign BAUD_TICK = (baud_cnt == 16'(BAUD_DIV - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      baud_cnt <= '0;
    end else if (BAUD_TICK) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + 16'd1;
    end
  end

  // Round-robin search starting just after the last winner.
  always_comb begin
    win     = last;
    any_req = 1'b0;
    for (int unsigned i = 1; i <= 4; i++) begin
      if (!any_req && REQ[2'(last + 2'(i))]) begin
        win     = 2'(last + 2'(i));
        any_req = 1'b1;
      end
    end
  end

  // A limit of 0 is treated as 1 so the counters can never run past it.
  assign timeout_hit = ({1'b0, tick_cnt} + 17'd1) >= 17'(TIMEOUT_TICKS);
  assign gap_done    = ({1'b0, tick_cnt} + 17'd1) >= 17'(GAP_TICKS);

  always_comb begin
    state_nxt    = state;
    tick_cnt_nxt = tick_cnt;
    GNT          = '0;
    grant        = 1'b0;
    err_set      = 1'b0;
    frame_done   = 1'b0;
    case (state)
      IDLE: begin
        tick_cnt_nxt = '0;
        if (any_req && EOT) begin
          GNT       = 4'b0001 << win;
          grant     = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        if (!EOT) begin
          state_nxt    = SEND;
          tick_cnt_nxt = '0;
        end else if (BAUD_TICK) begin
          if (timeout_hit) begin
            err_set      = 1'b1;
            state_nxt    = IDLE;
            tick_cnt_nxt = '0;
          end else begin
            tick_cnt_nxt = tick_cnt + 16'd1;
          end
        end
      end
      SEND: begin
        tick_cnt_nxt = '0;
        if (EOT) begin
          frame_done = 1'b1;
          state_nxt  = (GAP_TICKS == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (BAUD_TICK) begin
          if (gap_done) begin
            state_nxt    = IDLE;
            tick_cnt_nxt = '0;
          end else begin
            tick_cnt_nxt = tick_cnt + 16'd1;
          end
        end
      end
      default: begin
        state_nxt    = IDLE;
        tick_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      tick_cnt <= '0;
      last     <= 2'd3;
      TX_DATA  <= '0;
      OWNER    <= '0;
      ERR      <= 1'b0;
    end else begin
      state    <= state_nxt;
      tick_cnt <= tick_cnt_nxt;
      if (grant) begin
        last    <= win;
        OWNER   <= win;
        TX_DATA <= DIN[8*win +: 8];
      end
      if (err_set) begin
        ERR <= 1'b1;
      end
    end
  end

  assign STT  = (state == START);
  assign BUSY = (state != IDLE);

`ifdef RS232_TX_SCHED_CNT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      FRAMES <= '0;
    end else if (frame_done) begin
      FRAMES <= FRAMES + 16'd1;
    end
  end
`endif

endmodule
